// File: rtl/seg_display_arbiter_if.sv
// Requester-side bus of the shared seven-segment display arbiter:
// per-requester request levels and patterns in; grant, display pattern and busy out.
interface seg_display_arbiter_if #(
  parameter int NUMREQ   = 4,
  parameter int NUMCELLS = 4
);
  logic [NUMREQ-1:0]            req;
  logic [8*NUMCELLS*NUMREQ-1:0] req_val;
  logic [8*NUMCELLS-1:0]        r_val;
  logic [NUMREQ-1:0]            gnt;
  logic                         busy;

  modport master (
    output req, req_val,
    input  r_val, gnt, busy
  );

  modport slave (
    input  req, req_val,
    output r_val, gnt, busy
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner selection for a single multi-cell seven-segment display,
// with a minimum hold per owner and an optional blanking gap between owners.
module seg_display_arbiter #(
  parameter int NUMREQ       = 4,
  parameter int NUMCELLS     = 4,
  parameter int HOLD_CYCLES  = 16,
  parameter int BLANK_CYCLES = 2,
  parameter logic [8*NUMCELLS-1:0] IDLE_PATTERN = {(8*NUMCELLS){1'b0}}
) (
  input  logic                 clock,
  input  logic                 reset,
  seg_display_arbiter_if.slave bus
);

  localparam int CW         = 8 * NUMCELLS;
  localparam int PW         = (NUMREQ > 1) ? $clog2(NUMREQ) : 1;
  localparam int HW         = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int BW         = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam int HOLD_LOAD  = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int BLANK_LOAD = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [PW-1:0]      ptr_r, ptr_s;
  logic [PW-1:0]      owner_r, owner_s;
  logic [HW-1:0]      hold_cnt_r, hold_cnt_s;
  logic [BW-1:0]      blank_cnt_r, blank_cnt_s;
  logic [NUMREQ-1:0]  gnt_r, gnt_s;
  logic [CW-1:0]      r_val_r, r_val_s;
  logic               busy_r, busy_s;

  logic [PW:0]        pick_ptr_s;
  logic [PW:0]        pick_next_s;
  logic [PW-1:0]      next_ptr_s;
  logic               others_s;
  logic [CW-1:0]      owner_val_s;
  logic [CW-1:0]      ptr_win_val_s;
  logic [CW-1:0]      next_win_val_s;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
    if (idx == PW'(NUMREQ - 1)) begin
      return {PW{1'b0}};
    end else begin
      return idx + PW'(1);
    end
  endfunction

  // Returns {found, index} of the first set request scanning upward from start.
  function automatic logic [PW:0] rr_pick(input logic [NUMREQ-1:0] r,
                                          input logic [PW-1:0]     start);
    logic [PW-1:0] idx;
    logic [PW-1:0] win;
    logic          found;
    idx   = start;
    win   = start;
    found = 1'b0;
    for (int i = 0; i < NUMREQ; i++) begin
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = wrap_inc(idx);
    end
    return {found, win};
  endfunction

  function automatic logic [NUMREQ-1:0] one_hot(input logic [PW-1:0] idx);
    return {{(NUMREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign next_ptr_s     = wrap_inc(owner_r);
  assign pick_ptr_s     = rr_pick(bus.req, ptr_r);
  assign pick_next_s    = rr_pick(bus.req, next_ptr_s);
  assign others_s       = |(bus.req & ~gnt_r);
  assign owner_val_s    = bus.req_val[int'(owner_r) * CW +: CW];
  assign ptr_win_val_s  = bus.req_val[int'(pick_ptr_s[PW-1:0]) * CW +: CW];
  assign next_win_val_s = bus.req_val[int'(pick_next_s[PW-1:0]) * CW +: CW];

  // Next-state and next-output computation for the IDLE/SHOW/BLANK machine.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    owner_s     = owner_r;
    hold_cnt_s  = hold_cnt_r;
    blank_cnt_s = blank_cnt_r;
    gnt_s       = gnt_r;
    r_val_s     = r_val_r;
    busy_s      = busy_r;

    case (state_r)
      ST_IDLE: begin
        if (pick_ptr_s[PW]) begin
          state_s    = ST_SHOW;
          owner_s    = pick_ptr_s[PW-1:0];
          gnt_s      = one_hot(pick_ptr_s[PW-1:0]);
          r_val_s    = ptr_win_val_s;
          hold_cnt_s = HW'(HOLD_LOAD);
          busy_s     = 1'b1;
        end else begin
          gnt_s   = {NUMREQ{1'b0}};
          r_val_s = IDLE_PATTERN;
          busy_s  = 1'b0;
        end
      end

      ST_SHOW: begin
        // A departed owner leaves its last pattern frozen on the display.
        if (bus.req[owner_r]) begin
          r_val_s = owner_val_s;
        end else begin
          r_val_s = r_val_r;
        end

        if (hold_cnt_r != {HW{1'b0}}) begin
          hold_cnt_s = hold_cnt_r - HW'(1);
        end else if (others_s) begin
          ptr_s = next_ptr_s;
          if (BLANK_CYCLES > 0) begin
            state_s     = ST_BLANK;
            gnt_s       = {NUMREQ{1'b0}};
            r_val_s     = IDLE_PATTERN;
            blank_cnt_s = BW'(BLANK_LOAD);
          end else begin
            // Scanning from owner+1 always reaches another requester before the owner.
            owner_s    = pick_next_s[PW-1:0];
            gnt_s      = one_hot(pick_next_s[PW-1:0]);
            r_val_s    = next_win_val_s;
            hold_cnt_s = HW'(HOLD_LOAD);
          end
        end else if (bus.req[owner_r]) begin
          state_s = ST_SHOW;
        end else begin
          state_s = ST_IDLE;
          gnt_s   = {NUMREQ{1'b0}};
          r_val_s = IDLE_PATTERN;
          busy_s  = 1'b0;
        end
      end

      ST_BLANK: begin
        if (blank_cnt_r != {BW{1'b0}}) begin
          blank_cnt_s = blank_cnt_r - BW'(1);
        end else if (pick_ptr_s[PW]) begin
          state_s    = ST_SHOW;
          owner_s    = pick_ptr_s[PW-1:0];
          gnt_s      = one_hot(pick_ptr_s[PW-1:0]);
          r_val_s    = ptr_win_val_s;
          hold_cnt_s = HW'(HOLD_LOAD);
          busy_s     = 1'b1;
        end else begin
          state_s = ST_IDLE;
          gnt_s   = {NUMREQ{1'b0}};
          r_val_s = IDLE_PATTERN;
          busy_s  = 1'b0;
        end
      end

      default: begin
        state_s = ST_IDLE;
        gnt_s   = {NUMREQ{1'b0}};
        r_val_s = IDLE_PATTERN;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {PW{1'b0}};
      owner_r     <= {PW{1'b0}};
      hold_cnt_r  <= {HW{1'b0}};
      blank_cnt_r <= {BW{1'b0}};
      gnt_r       <= {NUMREQ{1'b0}};
      r_val_r     <= IDLE_PATTERN;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      owner_r     <= owner_s;
      hold_cnt_r  <= hold_cnt_s;
      blank_cnt_r <= blank_cnt_s;
      gnt_r       <= gnt_s;
      r_val_r     <= r_val_s;
      busy_r      <= busy_s;
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.r_val = r_val_r;
  assign bus.busy  = busy_r;

endmodule
